// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipeline_hazard_ctrl_pkg;

  localparam int REG_W_DEF     = 5;
  localparam int DRAIN_CYC_DEF = 3;
  localparam int CNT_W_DEF     = 16;

  // Encoding a pipeline latch loads when it is flushed or bubbled
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic [2:0] {
    RUN        = 3'd0,
    LD_STALL   = 3'd1,
    MEM_WAIT   = 3'd2,
    HALT_DRAIN = 3'd3,
    HALTED     = 3'd4,
    STEP       = 3'd5
  } state_t;

endpackage

// File: rtl/pipeline_hazard_ctrl_load_use_detect.sv
// Combinational load-use comparator: a load in EX writes a register the ID instruction reads.
module load_use_detect
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int REG_W = REG_W_DEF
) (
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rt,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_rd,
  output logic             load_use
);

  // r0 is hardwired to zero, so a load targeting it never creates a dependency
  assign load_use = id_valid & ex_mem_read & (ex_rd != '0) &
                    ((ex_rd == id_rs) | (id_uses_rt & (ex_rd == id_rt)));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush scheduler for the 5-stage pipeline: latch enables, IF_ID flush, ID_EX bubble, debug halt/step.
// Define HAZARD_STATS_EN to build the saturating stall_cycles/flush_count statistics counters.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int REG_W     = REG_W_DEF,
  parameter int DRAIN_CYC = DRAIN_CYC_DEF,
  parameter int CNT_W     = CNT_W_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rt,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             branch_taken,
  input  logic             dmem_wait,
  input  logic             halt_req,
  input  logic             step_req,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic             ex_mem_en,
  output logic             mem_wb_en,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  localparam int DRAIN_W = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_CYC - 1);

  state_t             state, state_next;
  logic [DRAIN_W-1:0] drain, drain_next;
  logic               load_use;

  load_use_detect #(.REG_W(REG_W)) u_load_use_detect (
    .id_valid    (id_valid),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_uses_rt  (id_uses_rt),
    .ex_mem_read (ex_mem_read),
    .ex_rd       (ex_rd),
    .load_use    (load_use)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= RUN;
      drain <= '0;
    end else begin
      state <= state_next;
      drain <= drain_next;
    end
  end

  always_comb begin
    state_next   = state;
    drain_next   = drain;
    pc_en        = 1'b1;
    if_id_en     = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    ex_mem_en    = 1'b1;
    mem_wb_en    = 1'b1;
    halted       = 1'b0;

    case (state)
      RUN: begin
        if (dmem_wait) begin
          pc_en      = 1'b0;
          if_id_en   = 1'b0;
          ex_mem_en  = 1'b0;
          mem_wb_en  = 1'b0;
          state_next = MEM_WAIT;
        end else if (load_use) begin
          pc_en        = 1'b0;
          if_id_en     = 1'b0;
          id_ex_bubble = 1'b1;
          state_next   = LD_STALL;
        end else if (branch_taken) begin
          if_id_flush = 1'b1;
        end else if (halt_req) begin
          pc_en        = 1'b0;
          if_id_en     = 1'b0;
          id_ex_bubble = 1'b1;
          drain_next   = '0;
          state_next   = HALT_DRAIN;
        end
      end

      // The stalled consumer advances this cycle; its hazard was already resolved
      LD_STALL: begin
        if (dmem_wait) begin
          pc_en      = 1'b0;
          if_id_en   = 1'b0;
          ex_mem_en  = 1'b0;
          mem_wb_en  = 1'b0;
          state_next = MEM_WAIT;
        end else begin
          state_next = RUN;
        end
      end

      MEM_WAIT: begin
        if (dmem_wait) begin
          pc_en     = 1'b0;
          if_id_en  = 1'b0;
          ex_mem_en = 1'b0;
          mem_wb_en = 1'b0;
        end else begin
          state_next = RUN;
        end
      end

      // Back half keeps flowing bubbles until the older instructions have retired
      HALT_DRAIN: begin
        pc_en        = 1'b0;
        if_id_en     = 1'b0;
        id_ex_bubble = 1'b1;
        if (dmem_wait) begin
          ex_mem_en = 1'b0;
          mem_wb_en = 1'b0;
        end else if (drain == DRAIN_LAST) begin
          state_next = HALTED;
        end else begin
          drain_next = drain + 1'b1;
        end
      end

      HALTED: begin
        halted       = 1'b1;
        pc_en        = 1'b0;
        if_id_en     = 1'b0;
        id_ex_bubble = 1'b1;
        if (!halt_req) begin
          state_next = RUN;
        end else if (step_req) begin
          state_next = STEP;
        end
      end

      STEP: begin
        if (dmem_wait) begin
          pc_en     = 1'b0;
          if_id_en  = 1'b0;
          ex_mem_en = 1'b0;
          mem_wb_en = 1'b0;
        end else begin
          drain_next = '0;
          state_next = halt_req ? HALT_DRAIN : RUN;
        end
      end

      default: state_next = RUN;
    endcase

    // Reset holds the front end and pushes NOPs into IF_ID and ID_EX
    if (reset) begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
      ex_mem_en    = 1'b1;
      mem_wb_en    = 1'b1;
      halted       = 1'b0;
    end
  end

`ifdef HAZARD_STATS_EN
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  always_ff @(posedge clock) begin
    if (reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (!pc_en && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
      if (if_id_flush && (flush_cnt != '1)) begin
        flush_cnt <= flush_cnt + 1'b1;
      end
    end
  end

  assign stall_cycles = stall_cnt;
  assign flush_count  = flush_cnt;
`else
  assign stall_cycles = '0;
  assign flush_count  = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed-vector bench for pipeline_hazard_ctrl; counter checks are added when HAZARD_STATS_EN is defined.
module tb_pipeline_hazard_ctrl;

  localparam int REG_W = 5;
  localparam int CNT_W = 16;

  // Output vector order: {pc_en, if_id_en, if_id_flush, id_ex_bubble, ex_mem_en, mem_wb_en, halted}
  localparam logic [6:0] O_DEF    = 7'b1100110;
  localparam logic [6:0] O_RESET  = 7'b0011110;
  localparam logic [6:0] O_STALL  = 7'b0001110;
  localparam logic [6:0] O_FLUSH  = 7'b1110110;
  localparam logic [6:0] O_FREEZE = 7'b0000000;
  localparam logic [6:0] O_HALTED = 7'b0001111;

  logic             clock = 1'b0;
  logic             reset;
  logic             id_valid, id_uses_rt, ex_mem_read;
  logic [REG_W-1:0] id_rs, id_rt, ex_rd;
  logic             branch_taken, dmem_wait, halt_req, step_req;
  logic             pc_en, if_id_en, if_id_flush, id_ex_bubble, ex_mem_en, mem_wb_en, halted;
  logic [CNT_W-1:0] stall_cycles, flush_count;
  logic [6:0]       outs;

  int               checks = 0;
  int               errors = 0;
  logic [CNT_W-1:0] exp_stall = '0;
  logic [CNT_W-1:0] exp_flush = '0;

  always #5 clock = ~clock;

  assign outs = {pc_en, if_id_en, if_id_flush, id_ex_bubble, ex_mem_en, mem_wb_en, halted};

  pipeline_hazard_ctrl #(.REG_W(REG_W), .DRAIN_CYC(3), .CNT_W(CNT_W)) dut (
    .clock        (clock),
    .reset        (reset),
    .id_valid     (id_valid),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_uses_rt   (id_uses_rt),
    .ex_mem_read  (ex_mem_read),
    .ex_rd        (ex_rd),
    .branch_taken (branch_taken),
    .dmem_wait    (dmem_wait),
    .halt_req     (halt_req),
    .step_req     (step_req),
    .pc_en        (pc_en),
    .if_id_en     (if_id_en),
    .if_id_flush  (if_id_flush),
    .id_ex_bubble (id_ex_bubble),
    .ex_mem_en    (ex_mem_en),
    .mem_wb_en    (mem_wb_en),
    .halted       (halted),
    .stall_cycles (stall_cycles),
    .flush_count  (flush_count)
  );

  task automatic check_output(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic apply_stimulus(input logic v, input logic [REG_W-1:0] rs, input logic [REG_W-1:0] rt,
                                input logic urt, input logic mrd, input logic [REG_W-1:0] rd,
                                input logic br, input logic dw, input logic hr, input logic sr);
    id_valid     = v;
    id_rs        = rs;
    id_rt        = rt;
    id_uses_rt   = urt;
    ex_mem_read  = mrd;
    ex_rd        = rd;
    branch_taken = br;
    dmem_wait    = dw;
    halt_req     = hr;
    step_req     = sr;
  endtask

  task automatic clear_inputs();
    apply_stimulus(1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Checks the current cycle's outputs, then advances one clock and updates the counter model
  task automatic expect_cycle(input string tag, input logic [6:0] exp);
    #1;
    check_output(tag, {25'd0, outs}, {25'd0, exp});
`ifdef HAZARD_STATS_EN
    if (!reset) begin
      check_output({tag, "_stall_cnt"}, {16'd0, stall_cycles}, {16'd0, exp_stall});
      check_output({tag, "_flush_cnt"}, {16'd0, flush_count}, {16'd0, exp_flush});
    end
`endif
    if (reset) begin
      exp_stall = '0;
      exp_flush = '0;
    end else begin
      if (!exp[6] && exp_stall != '1) exp_stall = exp_stall + 1'b1;
      if (exp[4] && exp_flush != '1) exp_flush = exp_flush + 1'b1;
    end
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    clear_inputs();
    repeat (2) @(posedge clock);
    #1;
    expect_cycle("reset_outputs", O_RESET);
    reset = 1'b0;

    // lw r3 in EX, add r4,r3,r5 in ID
    apply_stimulus(1'b1, 5'd3, 5'd5, 1'b1, 1'b1, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_cycle("load_use_stall", O_STALL);
    expect_cycle("ld_stall_release", O_DEF);
    clear_inputs();
    expect_cycle("after_load_use", O_DEF);

    apply_stimulus(1'b1, 5'd0, 5'd6, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_cycle("rd_zero_no_stall", O_DEF);
    apply_stimulus(1'b1, 5'd2, 5'd7, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_cycle("rt_unused_no_stall", O_DEF);
    apply_stimulus(1'b1, 5'd2, 5'd7, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_cycle("rt_used_stall", O_STALL);
    clear_inputs();
    expect_cycle("rt_stall_release", O_DEF);

    apply_stimulus(1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    expect_cycle("branch_flush", O_FLUSH);
    clear_inputs();
    expect_cycle("branch_one_cycle", O_DEF);

    apply_stimulus(1'b1, 5'd3, 5'd5, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0);
    expect_cycle("branch_with_load_use", O_STALL);
    clear_inputs();
    expect_cycle("branch_lu_release", O_DEF);
    apply_stimulus(1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    expect_cycle("branch_reevaluated", O_FLUSH);

    apply_stimulus(1'b1, 5'd3, 5'd5, 1'b1, 1'b1, 5'd3, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) expect_cycle($sformatf("dmem_freeze_%0d", i), O_FREEZE);
    apply_stimulus(1'b1, 5'd3, 5'd5, 1'b1, 1'b1, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_cycle("mem_wait_exit", O_DEF);
    expect_cycle("load_use_after_wait", O_STALL);
    clear_inputs();
    expect_cycle("lu_after_wait_release", O_DEF);

    apply_stimulus(1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    expect_cycle("step_ignored_in_run", O_DEF);

    apply_stimulus(1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
    expect_cycle("halt_accept", O_STALL);
    for (int i = 0; i < 3; i++) expect_cycle($sformatf("halt_drain_%0d", i), O_STALL);
    expect_cycle("halted", O_HALTED);
    step_req = 1'b1;
    expect_cycle("step_request", O_HALTED);
    step_req = 1'b0;
    expect_cycle("step_cycle", O_DEF);
    for (int i = 0; i < 3; i++) expect_cycle($sformatf("step_drain_%0d", i), O_STALL);
    expect_cycle("halted_again", O_HALTED);
    halt_req = 1'b0;
    expect_cycle("unhalt_request", O_HALTED);
    expect_cycle("resumed_run", O_DEF);

    halt_req = 1'b1;
    for (int i = 0; i < 4; i++) expect_cycle($sformatf("rehalt_%0d", i), O_STALL);
    expect_cycle("rehalted", O_HALTED);
    reset = 1'b1;
    expect_cycle("reset_in_halted", O_RESET);
    reset = 1'b0;
    halt_req = 1'b0;
    expect_cycle("run_after_halt_reset", O_DEF);

    dmem_wait = 1'b1;
    expect_cycle("wait_enter", O_FREEZE);
    expect_cycle("wait_hold", O_FREEZE);
    reset = 1'b1;
    expect_cycle("reset_in_mem_wait", O_RESET);
    reset = 1'b0;
    dmem_wait = 1'b0;
    expect_cycle("run_after_wait_reset", O_DEF);
    expect_cycle("run_steady", O_DEF);

`ifdef HAZARD_STATS_EN
    dmem_wait = 1'b1;
    repeat (65540) @(posedge clock);
    #2;
    check_output("stall_saturated", {16'd0, stall_cycles}, 32'h0000_FFFF);
    @(posedge clock);
    #2;
    check_output("stall_saturation_holds", {16'd0, stall_cycles}, 32'h0000_FFFF);
    dmem_wait = 1'b0;
`else
    #1;
    check_output("stall_cycles_tied", {16'd0, stall_cycles}, 32'd0);
    check_output("flush_count_tied", {16'd0, flush_count}, 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
